// File: rtl/adder_result_buffer.sv
// adder_result_buffer
// Capture stage behind carry_lookahead_adder. It takes the WIDTH+1 bit adder
// result under valid/ready and holds it in a DEPTH-entry first-word-fall-through
// FIFO. The oldest entry is shown to the consumer as a sum and a carry bit.
// Optional feature macro: ADDER_CARRY_STATS_EN. It adds a saturating 16-bit
// count of accepted results that have the carry bit set. The port list is the
// same with or without the macro.

module adder_result_buffer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clear,
   input  logic [WIDTH:0]           i_result,
   input  logic                     i_valid,
   output logic                     o_ready,
   output logic [WIDTH-1:0]         o_sum,
   output logic                     o_carry,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic [15:0]              o_carry_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH:0]  r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [LW-1:0]   r_level;

   logic            w_full;
   logic            w_empty;
   logic            w_wr_en;
   logic            w_rd_en;
   logic [WIDTH:0]  w_head;

   // Full and empty come only from the registered occupancy.
   // They never use a pointer comparison, and they have no path from the handshake inputs.
   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_wr_en = i_valid && !w_full;
   assign w_rd_en = i_ready && !w_empty;

   // Storage array: holds data only. Occupancy tracking decides which entries count as valid.
   always_ff @(posedge clk) begin
      if (w_wr_en && !i_clear) begin
         r_mem[r_wr_ptr] <= i_result;
      end
   end

   // Pointer and occupancy state. A clear takes priority over a write or read in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr_en, w_rd_en})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign w_head  = r_mem[r_rd_ptr];
   assign o_ready = !w_full;
   assign o_valid = !w_empty;
   assign o_level = r_level;
   // When the FIFO is empty, the head outputs are forced to zero. This hides the stale contents of the storage array.
   assign o_sum   = w_empty ? '0   : w_head[WIDTH-1:0];
   assign o_carry = w_empty ? 1'b0 : w_head[WIDTH];

`ifdef ADDER_CARRY_STATS_EN
   logic [15:0] r_carry_count;

   // Counts accepted writes whose carry bit is set. The count saturates.
   // A write that lands in a clear cycle is discarded, so it is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_carry_count <= '0;
      end else if (i_clear) begin
         r_carry_count <= '0;
      end else if (w_wr_en && i_result[WIDTH] && (r_carry_count != 16'hFFFF)) begin
         r_carry_count <= r_carry_count + 16'd1;
      end
   end

   assign o_carry_count = r_carry_count;
`else
   assign o_carry_count = 16'h0000;
`endif

endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed testbench for adder_result_buffer with WIDTH=16 and DEPTH=4.
module tb_adder_result_buffer;

   logic        clk;
   logic        rst_n;
   logic        i_clear;
   logic [16:0] i_result;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] o_sum;
   logic        o_carry;
   logic        o_valid;
   logic        i_ready;
   logic [2:0]  o_level;
   logic [15:0] o_carry_count;

   int checks = 0;
   int errors = 0;

   adder_result_buffer #(.WIDTH(16), .DEPTH(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_clear       (i_clear),
      .i_result      (i_result),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .o_sum         (o_sum),
      .o_carry       (o_carry),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_level       (o_level),
      .o_carry_count (o_carry_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected carry count: the counter exists only when the macro is defined.
   function automatic logic [15:0] exp_cnt(input logic [15:0] n);
`ifdef ADDER_CARRY_STATS_EN
      return n;
`else
      return 16'h0000;
`endif
   endfunction

   // Runs one clock with the given handshake inputs. Outputs are then stable at 1 ns after the edge.
   task automatic do_cycle(input logic v, input logic [16:0] d, input logic r);
      i_valid  = v;
      i_result = d;
      i_ready  = r;
      $display("cycle: valid=%b data=%h ready=%b | head valid=%b sum=%h carry=%b level=%0d",
               v, d, r, o_valid, o_sum, o_carry, o_level);
      @(posedge clk);
      #1;
      i_valid  = 1'b0;
      i_ready  = 1'b0;
      i_result = '0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_result = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
      checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", o_level); end
      checks++; if (o_sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", o_sum); end
      checks++; if (o_carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", o_carry); end
      checks++; if (o_carry_count !== 16'h0000) begin errors++; $display("FAIL reset_cnt: got %h want 0000", o_carry_count); end
   endtask

   task automatic test_single_entry;
      do_cycle(1'b1, 17'h00001, 1'b0);
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", o_valid); end
      checks++; if (o_sum !== 16'h0001) begin errors++; $display("FAIL single_sum: got %h want 0001", o_sum); end
      checks++; if (o_carry !== 1'b0) begin errors++; $display("FAIL single_carry: got %b want 0", o_carry); end
      checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d want 1", o_level); end
      do_cycle(1'b0, 17'h00000, 1'b1);
      checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL single_drain_level: got %0d want 0", o_level); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b want 0", o_valid); end
      checks++; if (o_sum !== 16'h0000) begin errors++; $display("FAIL single_empty_sum: got %h want 0000", o_sum); end
      // A read request while the FIFO is empty must be ignored.
      do_cycle(1'b0, 17'h00000, 1'b1);
      checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL empty_read_level: got %0d want 0", o_level); end
   endtask

   task automatic test_fill_overflow;
      logic [16:0] vec [4];
      vec[0] = 17'h00001; vec[1] = 17'h00108; vec[2] = 17'h00528; vec[3] = 17'h02008;
      for (int i = 0; i < 4; i++) begin
         do_cycle(1'b1, vec[i], 1'b0);
         checks++; if (o_level !== 3'(i + 1)) begin errors++; $display("FAIL fill_level_%0d: got %0d want %0d", i, o_level, i + 1); end
      end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", o_ready); end
      do_cycle(1'b1, 17'h0FFFF, 1'b0);
      checks++; if (o_level !== 3'd4) begin errors++; $display("FAIL overflow_level: got %0d want 4", o_level); end
      checks++; if (o_sum !== 16'h0001) begin errors++; $display("FAIL full_head: got %h want 0001", o_sum); end
      // When the FIFO is full and a read happens in the same cycle, the write must still be dropped.
      do_cycle(1'b1, 17'h0AAAA, 1'b1);
      checks++; if (o_level !== 3'd3) begin errors++; $display("FAIL full_rw_level: got %0d want 3", o_level); end
      for (int i = 1; i < 4; i++) begin
         checks++; if ({o_carry, o_sum} !== vec[i]) begin errors++; $display("FAIL drain_%0d: got %h want %h", i, {o_carry, o_sum}, vec[i]); end
         do_cycle(1'b0, 17'h00000, 1'b1);
      end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %b want 0", o_valid); end
      checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL drain_empty_level: got %0d want 0", o_level); end
   endtask

   task automatic test_back_to_back;
      logic [16:0] exp_q [8];
      for (int i = 0; i < 8; i++) exp_q[i] = 17'h00010 + 17'(i * 17'h00111);
      do_cycle(1'b1, exp_q[0], 1'b0);
      do_cycle(1'b1, exp_q[1], 1'b0);
      checks++; if (o_level !== 3'd2) begin errors++; $display("FAIL b2b_start_level: got %0d want 2", o_level); end
      for (int k = 0; k < 6; k++) begin
         checks++; if ({o_carry, o_sum} !== exp_q[k]) begin errors++; $display("FAIL b2b_head_%0d: got %h want %h", k, {o_carry, o_sum}, exp_q[k]); end
         do_cycle(1'b1, exp_q[k + 2], 1'b1);
         checks++; if (o_level !== 3'd2) begin errors++; $display("FAIL b2b_level_%0d: got %0d want 2", k, o_level); end
      end
      for (int k = 6; k < 8; k++) begin
         checks++; if ({o_carry, o_sum} !== exp_q[k]) begin errors++; $display("FAIL b2b_tail_%0d: got %h want %h", k, {o_carry, o_sum}, exp_q[k]); end
         do_cycle(1'b0, 17'h00000, 1'b1);
      end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", o_valid); end
   endtask

   task automatic test_carry;
      for (int i = 0; i < 3; i++) do_cycle(1'b1, 17'h1FFFF, 1'b0);
      checks++; if (o_sum !== 16'hFFFF) begin errors++; $display("FAIL carry_sum: got %h want ffff", o_sum); end
      checks++; if (o_carry !== 1'b1) begin errors++; $display("FAIL carry_bit: got %b want 1", o_carry); end
      checks++; if (o_level !== 3'd3) begin errors++; $display("FAIL carry_level: got %0d want 3", o_level); end
      checks++; if (o_carry_count !== exp_cnt(16'd3)) begin errors++; $display("FAIL carry_count: got %h want %h", o_carry_count, exp_cnt(16'd3)); end
   endtask

   task automatic test_clear_and_reset;
      // The FIFO is at level 3 here, left that way by test_carry.
      i_clear = 1'b1;
      do_cycle(1'b1, 17'h1FFFF, 1'b0);
      i_clear = 1'b0;
      checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL clear_level: got %0d want 0", o_level); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b want 0", o_valid); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b want 1", o_ready); end
      checks++; if (o_carry_count !== 16'h0000) begin errors++; $display("FAIL clear_cnt: got %h want 0000", o_carry_count); end
      do_cycle(1'b1, 17'h00005, 1'b0);
      checks++; if (o_sum !== 16'h0005) begin errors++; $display("FAIL post_clear_head: got %h want 0005", o_sum); end
      do_cycle(1'b1, 17'h10006, 1'b0);
      checks++; if (o_level !== 3'd2) begin errors++; $display("FAIL refill_level: got %0d want 2", o_level); end
      checks++; if (o_carry_count !== exp_cnt(16'd1)) begin errors++; $display("FAIL refill_cnt: got %h want %h", o_carry_count, exp_cnt(16'd1)); end
      // Drop the reset between clock edges. It must take effect with no clock edge.
      #2 rst_n = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", o_valid); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %b want 1", o_ready); end
      checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL async_level: got %0d want 0", o_level); end
      checks++; if (o_sum !== 16'h0000) begin errors++; $display("FAIL async_sum: got %h want 0000", o_sum); end
      checks++; if (o_carry_count !== 16'h0000) begin errors++; $display("FAIL async_cnt: got %h want 0000", o_carry_count); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      // The first write must be accepted on the first edge after reset is released.
      do_cycle(1'b1, 17'h00077, 1'b0);
      checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL release_level: got %0d want 1", o_level); end
      checks++; if (o_sum !== 16'h0077) begin errors++; $display("FAIL release_sum: got %h want 0077", o_sum); end
   endtask

   initial begin
      test_reset();
      test_single_entry();
      test_fill_overflow();
      test_back_to_back();
      test_carry();
      test_clear_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
